// File: rtl/jump_pkg.sv
// ============================================================================
// jump_pkg : shared encodings and defaults for the jump controller
// Rev 1.0
// ============================================================================
`default_nettype none

package jump_pkg;

   localparam int DEFAULT_PC_WIDTH  = 8;
   localparam int DEFAULT_RAS_DEPTH = 4;

   typedef enum logic [2:0] {
      JT_JMP  = 3'b000,
      JT_BEQ  = 3'b001,
      JT_BNE  = 3'b010,
      JT_CALL = 3'b011,
      JT_RET  = 3'b100
   } jmp_type_e;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_ERROR = 2'd2
   } state_e;

   // Reserved encodings fall through to not-taken so they behave as no request.
   function automatic logic jump_taken(input logic [2:0] jtype, input logic zero);
      logic taken;
      taken = 1'b0;
      case (jtype)
         JT_JMP:  taken = 1'b1;
         JT_BEQ:  taken = zero;
         JT_BNE:  taken = ~zero;
         JT_CALL: taken = 1'b1;
         JT_RET:  taken = 1'b1;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

`default_nettype wire

// File: rtl/jump_controller_if.sv
// ============================================================================
// jump_controller_if : request/status bundle between sequencer and controller
// Rev 1.0
// ============================================================================
`default_nettype none

interface jump_controller_if
   import jump_pkg::*;
#(
   parameter int PC_WIDTH = DEFAULT_PC_WIDTH
) ();

   logic                stall;
   logic                jmp_valid;
   logic [2:0]          jmp_type;
   logic                zero_flag;
   logic [PC_WIDTH-1:0] label;
   logic                jmp_ready;
   logic [PC_WIDTH-1:0] pc;
   logic                flush;
   logic                ras_error;

   modport master (
      output stall, jmp_valid, jmp_type, zero_flag, label,
      input  jmp_ready, pc, flush, ras_error
   );

   modport slave (
      input  stall, jmp_valid, jmp_type, zero_flag, label,
      output jmp_ready, pc, flush, ras_error
   );

endinterface

`default_nettype wire

// File: rtl/jump_ras.sv
// ============================================================================
// jump_ras : LIFO return-address stack, push/pop guarded by full/empty
// Rev 1.0
// ============================================================================
`default_nettype none

module jump_ras
   import jump_pkg::*;
#(
   parameter int WIDTH = DEFAULT_PC_WIDTH,
   parameter int DEPTH = DEFAULT_RAS_DEPTH
) (
   input  wire logic             clock,
   input  wire logic             reset,
   input  wire logic             push,
   input  wire logic             pop,
   input  wire logic [WIDTH-1:0] din,
   output logic      [WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CW-1:0]    count_q;
   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    rd_idx;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty & ~push;
   assign wr_idx  = AW'(count_q);
   assign rd_idx  = AW'(count_q - CW'(1));
   assign dout    = empty ? '0 : mem_q[rd_idx];

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else if (do_push) begin
         count_q <= count_q + CW'(1);
      end else if (do_pop) begin
         count_q <= count_q - CW'(1);
      end
   end

   // Storage needs no reset: entries are only read below the count.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem_q[wr_idx] <= din;
      end
   end

endmodule

`default_nettype wire

// File: rtl/jump_controller.sv
// ============================================================================
// jump_controller : PC sequencer with jumps, branches, call/return and flush
// Rev 1.0
// ============================================================================
`default_nettype none

module jump_controller
   import jump_pkg::*;
#(
   parameter int                  PC_WIDTH  = DEFAULT_PC_WIDTH,
   parameter int                  RAS_DEPTH = DEFAULT_RAS_DEPTH,
   parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
   input wire logic          clock,
   input wire logic          reset,
   jump_controller_if.slave  bus
);

   state_e              state_q;
   logic [PC_WIDTH-1:0] pc_q;
   logic                flush_q;
   logic                ras_error_q;

   logic [PC_WIDTH-1:0] pc_inc;
   logic [PC_WIDTH-1:0] target_d;
   logic [PC_WIDTH-1:0] ras_dout;
   logic                accept;
   logic                taken;
   logic                is_call;
   logic                is_ret;
   logic                ras_push;
   logic                ras_pop;
   logic                ras_full;
   logic                ras_empty;
   logic                fault;

   assign accept   = (state_q == ST_RUN) & ~bus.stall;
   assign taken    = accept & bus.jmp_valid & jump_taken(bus.jmp_type, bus.zero_flag);
   assign is_call  = taken & (bus.jmp_type == JT_CALL);
   assign is_ret   = taken & (bus.jmp_type == JT_RET);
   assign fault    = (is_call & ras_full) | (is_ret & ras_empty);
   assign ras_push = is_call & ~ras_full;
   assign ras_pop  = is_ret & ~ras_empty;
   assign pc_inc   = pc_q + PC_WIDTH'(1);
   assign target_d = is_ret ? ras_dout : bus.label;

   jump_ras #(
      .WIDTH (PC_WIDTH),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clock (clock),
      .reset (reset),
      .push  (ras_push),
      .pop   (ras_pop),
      .din   (pc_inc),
      .dout  (ras_dout),
      .full  (ras_full),
      .empty (ras_empty)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_RUN;
         pc_q        <= RESET_PC;
         flush_q     <= 1'b0;
         ras_error_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               flush_q <= 1'b0;
               if (fault) begin
                  state_q     <= ST_ERROR;
                  ras_error_q <= 1'b1;
               end else if (taken) begin
                  pc_q    <= target_d;
                  flush_q <= 1'b1;
                  state_q <= ST_FLUSH;
               end else if (accept) begin
                  pc_q <= pc_inc;
               end
            end
            ST_FLUSH: begin
               flush_q <= 1'b0;
               state_q <= ST_RUN;
            end
            ST_ERROR: begin
               flush_q <= 1'b0;
            end
            default: begin
               flush_q <= 1'b0;
               state_q <= ST_RUN;
            end
         endcase
      end
   end

   assign bus.jmp_ready = accept;
   assign bus.pc        = pc_q;
   assign bus.flush     = flush_q;
   assign bus.ras_error = ras_error_q;

endmodule

`default_nettype wire

// File: tb/tb_jump_controller.sv
// ============================================================================
// tb_jump_controller : directed + random checks against a queue-based model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_jump_controller;
   import jump_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   jump_controller_if #(.PC_WIDTH(8)) bus ();

   jump_controller #(
      .PC_WIDTH  (8),
      .RAS_DEPTH (4),
      .RESET_PC  (8'h00)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int compared   = 0;
   int mismatched = 0;

   // Reference model: pc as an integer, call stack as a queue.
   int m_pc;
   bit m_flush;
   bit m_err;
   bit m_busy;
   int m_stack[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_ready(input bit st);
      return !m_busy && !m_err && !st;
   endfunction

   task automatic m_step(input bit rs, input bit st, input bit v,
                         input int t, input bit z, input int lb);
      bit tk;
      int ra;
      if (rs) begin
         m_pc = 0; m_flush = 0; m_err = 0; m_busy = 0;
         m_stack.delete();
         return;
      end
      if (m_err) return;
      if (m_busy) begin
         m_busy = 0; m_flush = 0;
         return;
      end
      if (st) return;
      tk = v && (t == 0 || (t == 1 && z) || (t == 2 && !z) || t == 3 || t == 4);
      ra = (m_pc + 1) % 256;
      if (!tk) begin
         m_pc = ra;
         return;
      end
      if (t == 3) begin
         if (m_stack.size() >= 4) begin m_err = 1; return; end
         m_stack.push_back(ra);
         m_pc = lb;
      end else if (t == 4) begin
         if (m_stack.size() == 0) begin m_err = 1; return; end
         m_pc = m_stack.pop_back();
      end else begin
         m_pc = lb;
      end
      m_flush = 1;
      m_busy  = 1;
   endtask

   // Called one time unit after a rising edge; returns one unit after the next.
   task automatic cyc(input bit rs, input bit st, input bit v, input logic [2:0] t,
                      input bit z, input logic [7:0] lb, input string tag);
      reset         = rs;
      bus.stall     = st;
      bus.jmp_valid = v;
      bus.jmp_type  = t;
      bus.zero_flag = z;
      bus.label     = lb;
      #3;
      if (!rs) chk({tag, ".ready"}, bus.jmp_ready, m_ready(st));
      @(posedge clock);
      m_step(rs, st, v, int'(t), z, int'(lb));
      #1;
      chk({tag, ".pc"},    bus.pc,        m_pc);
      chk({tag, ".flush"}, bus.flush,     m_flush);
      chk({tag, ".err"},   bus.ras_error, m_err);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 3'd0, 0, 8'h00, "idle");
   endtask

   task automatic do_reset();
      cyc(1, 1, 1, 3'd3, 1, 8'hEE, "reset");
   endtask

   task automatic goto_pc(input int target);
      for (int i = 0; i < 300 && m_pc != target; i++) idle(1);
      chk("goto", bus.pc, target);
   endtask

   initial begin
      bus.stall = 0; bus.jmp_valid = 0; bus.jmp_type = 0; bus.zero_flag = 0; bus.label = 0;

      // Reset and free-running count with wrap.
      do_reset();
      idle(300);
      chk("wrap.pc", bus.pc, 300 % 256);

      // Unconditional jump with flush pulse.
      do_reset();
      goto_pc(8'h10);
      cyc(0, 0, 1, JT_JMP, 0, 8'h80, "jmp");
      chk("jmp.flush", bus.flush, 1);
      idle(2);
      chk("jmp.after", bus.pc, 8'h81);

      // Conditional branches and reserved encodings.
      goto_pc(8'h20);
      cyc(0, 0, 1, JT_BEQ, 0, 8'h40, "beq_nt");
      cyc(0, 0, 1, JT_BEQ, 1, 8'h40, "beq_t");
      idle(1);
      cyc(0, 0, 1, JT_BNE, 1, 8'h90, "bne_nt");
      cyc(0, 0, 1, JT_BNE, 0, 8'h90, "bne_t");
      idle(1);
      for (int r = 5; r < 8; r++) cyc(0, 0, 1, 3'(r), 1, 8'h11, "reserved");

      // Call / return round trip, then return on an empty stack.
      do_reset();
      goto_pc(8'h05);
      cyc(0, 0, 1, JT_CALL, 0, 8'h50, "call");
      idle(1);
      goto_pc(8'h52);
      cyc(0, 0, 1, JT_RET, 0, 8'h00, "ret");
      chk("ret.pc", bus.pc, 8'h06);
      idle(2);
      cyc(0, 0, 1, JT_RET, 0, 8'h00, "ret_empty");
      chk("ret_empty.err", bus.ras_error, 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, JT_JMP, 0, 8'h77, "err_hold");
      do_reset();

      // Nested calls fill the stack; the fifth overflows.
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 1, JT_CALL, 0, 8'(8'h30 + 8'(i * 16)), "call_n");
         if (!m_err) idle(1);
      end
      chk("overflow.err", bus.ras_error, 1);
      idle(2);
      do_reset();
      chk("clear.err", bus.ras_error, 0);

      // LIFO order across three nested calls.
      goto_pc(8'h03);
      cyc(0, 0, 1, JT_CALL, 0, 8'hA0, "lifo_c1"); idle(2);
      cyc(0, 0, 1, JT_CALL, 0, 8'hB0, "lifo_c2"); idle(3);
      cyc(0, 0, 1, JT_CALL, 0, 8'hC0, "lifo_c3"); idle(1);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1, JT_RET, 0, 8'h00, "lifo_ret");
         idle(1);
      end

      // Stall blocks acceptance; request taken on the first unstalled cycle.
      for (int i = 0; i < 3; i++) cyc(0, 1, 1, JT_JMP, 0, 8'h99, "stall");
      cyc(0, 0, 1, JT_JMP, 0, 8'h99, "unstall");
      chk("unstall.pc", bus.pc, 8'h99);
      cyc(0, 1, 1, JT_JMP, 0, 8'h10, "flush_stall");
      idle(1);

      // Reset wins in the middle of a flush.
      cyc(0, 0, 1, JT_JMP, 0, 8'h44, "pre_rst");
      do_reset();
      chk("midflush.pc", bus.pc, 8'h00);

      // Randomised traffic, weighted toward call/return.
      for (int i = 0; i < 1500; i++) begin
         bit          rs, st, v, z;
         logic [2:0]  t;
         logic [7:0]  lb;
         rs = ($urandom_range(0, 149) == 0) || (m_err && $urandom_range(0, 7) == 0);
         st = ($urandom_range(0, 4) == 0);
         v  = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 9))
            0, 1, 2: t = JT_CALL;
            3, 4, 5: t = JT_RET;
            6:       t = JT_BEQ;
            7:       t = JT_BNE;
            8:       t = JT_JMP;
            default: t = 3'($urandom_range(5, 7));
         endcase
         z  = 1'($urandom_range(0, 1));
         lb = 8'($urandom_range(0, 255));
         cyc(rs, st, v, t, z, lb, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
